lif_neuron_array: RTL and testbench
===================================

Name: lif_neuron_array

Overview:
- Parametrised multi-neuron leaky integrate-and-fire hidden layer; successor to the single-neuron hidden layer.
- Accumulates indexed synaptic inputs per neuron at sys_clk rate. On each snn_clk tick, updates all neurons sequentially through one shared LIF datapath and emits a registered spike vector.
- Sits between the input/weight stage and the output layer of the SNN pipeline.

Parameters:
- N_NEURONS, 4, number of neurons (>=1).
- IDX_W, $clog2(N_NEURONS) min 1, neuron index width.
- DATA_W, 16, signed input/bias width.
- ACC_W, 24, signed accumulator and membrane width (> DATA_W).
- SHIFT_VALUE, 2, leak shift (tau = 2^SHIFT_VALUE).
- THRESHOLD, 100, signed firing threshold, ACC_W wide.
- REFRAC_TICKS, 2, refractory length in ticks (used only with the optional feature).

Ports:
- sys_clk  in  1  system clock. Reset rst, synchronous, active-high; clock sys_clk.
- rst  in  1  synchronous active-high reset.
- snn_clk  in  1  tick strobe, one sys_clk cycle wide.
- boot_mode  in  1  1 = din/din_idx load a bias; 0 = din is synaptic input.
- data_ready  in  1  din/din_idx valid this cycle.
- din_idx  in  IDX_W  target neuron.
- din  in  DATA_W  signed input or bias value.
- spike  out  N_NEURONS  spike vector from the last completed update; held until the next one completes.
- spike_valid  out  1  one-cycle pulse when spike is updated.
- busy  out  1  update sweep in progress.
- overrun  out  1  sticky; a tick arrived while busy.

Behaviour:
- Reset: all accumulators, shadow copies, membranes, biases, refractory counters, spike, spike_valid, busy and overrun go to 0. FSM goes to IDLE. Reset mid-sweep aborts the sweep with no spike_valid.
- Accumulate: boot_mode=0 && data_ready adds sign-extended din into acc[din_idx], saturating to the ACC_W signed range.
- Bias load: boot_mode=1 && data_ready writes bias[din_idx]; no accumulation in that cycle.
- Out-of-range din_idx (>= N_NEURONS): write dropped, no other effect.
- Tick in IDLE (cycle T): copy acc[] to shadow[], clear acc[], set busy, enter UPDATE with i=0.
- data_ready coincident with a tick: din lands in the freshly cleared acc for the next window; it is not lost.
- Tick while busy: ignored, overrun<=1. Accumulation continues.
- UPDATE, one neuron per cycle (neuron i at cycle T+1+i):
  - d = shadow[i] + bias[i] - v[i], computed at ACC_W+2 bits.
  - v_next = v[i] + (d >>> SHIFT_VALUE), arithmetic shift, saturated to ACC_W.
  - If v_next >= THRESHOLD: spk[i]=1 and v[i]<=0; else spk[i]=0 and v[i]<=v_next.
  - Comparison uses the new membrane value.
- DONE (cycle T+N_NEURONS+1): spike<=spk vector, spike_valid=1, busy=0, return to IDLE.
- Latency from tick to spike_valid: N_NEURONS+1 cycles. The next tick is accepted from the DONE cycle onward.
- spike_valid is 0 in all other cycles.

Optional Feature:
- Macro: LIF_REFRACTORY_EN.
- Defined: per-neuron counter loads REFRAC_TICKS when the neuron fires. On each later sweep where the counter is nonzero:
  - the neuron's shadow input is discarded, v stays 0 and spk=0;
  - the counter decrements.
- Undefined: no counters or logic are generated; neurons integrate on the sweep right after firing.

Decomposition:
- Shared package snn_pkg holds:
  - FSM state enum (IDLE, UPDATE, DONE);
  - a saturate-to-width function;
  - default width constants DATA_W_DEF and ACC_W_DEF.
- One natural sub-module: lif_update_core. It is the combinational LIF step plus threshold compare: inputs v, shadow, bias, refractory-active; outputs v_new, fire. It is shared across neurons by the sequential sweep.

Test Plan:
- Threshold hit, N=4, SHIFT=2, THR=100: data_ready din=400 on idx 0, then tick -> spike=4'b0001 and spike_valid exactly 5 cycles after the tick; v[0]=0.
- Leak integration: 200 into idx 1 on each of three ticks. v goes 50, then 87, then 115 -> spike[1]=1 on the third sweep only.
- Bias and negatives: boot load bias[2]=40, then din=-400 on idx 2 and tick -> v[2]=-90, no spike. Next tick with no input -> v=-90+(130>>>2)=-58.
- Boundaries, four checks:
  - data_ready coincident with a tick lands in the next window;
  - a tick while busy sets overrun and is otherwise ignored;
  - din_idx=5 is dropped;
  - 600 samples of 32767 into one neuron saturate acc at 8388607.
- Reset mid-UPDATE: no spike_valid; all outputs are 0 on the next cycle.
- With LIF_REFRACTORY_EN, REFRAC_TICKS=2: neuron 0 fires, then gets 400 per tick. No spike on the next two sweeps; spike on the third.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared types, width defaults and saturation helper for the SNN hidden-layer blocks.
package snn_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ACC_W_DEF  = 24;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        DONE   = 2'd2
    } lif_state_t;

    // Clamp a wide signed value into the signed range of a w-bit word (w <= 63).
    function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/lif_update_core.sv
// Combinational LIF step for one neuron: leak toward (shadow + bias), saturate, compare to threshold.
module lif_update_core
    import snn_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ACC_W       = ACC_W_DEF,
    parameter int SHIFT_VALUE = 2,
    parameter logic signed [ACC_W-1:0] THRESHOLD = 100
) (
    input  logic signed [ACC_W-1:0]  v,
    input  logic signed [ACC_W-1:0]  shadow,
    input  logic signed [DATA_W-1:0] bias,
    input  logic                     refrac_active,
    output logic signed [ACC_W-1:0]  v_new,
    output logic                     fire
);

    localparam int EXT_W = ACC_W + 2;

    logic signed [EXT_W-1:0] d;
    logic signed [EXT_W-1:0] step;
    logic signed [EXT_W-1:0] v_sum;
    logic signed [63:0]      v_sat;
    logic signed [ACC_W-1:0] v_cand;

    always_comb begin
        d      = EXT_W'(shadow) + EXT_W'(bias) - EXT_W'(v);
        step   = d >>> SHIFT_VALUE;
        v_sum  = EXT_W'(v) + step;
        v_sat  = sat_to_width(64'(v_sum), ACC_W);
        v_cand = v_sat[ACC_W-1:0];
        fire   = 1'b0;
        v_new  = '0;
        // A refractory neuron discards its input and stays pinned at rest.
        if (!refrac_active) begin
            if (v_cand >= THRESHOLD) begin
                fire = 1'b1;
            end else begin
                v_new = v_cand;
            end
        end
    end

endmodule

// File: rtl/lif_neuron_array.sv
// Multi-neuron LIF hidden layer: per-neuron accumulators, one shared update core swept per snn_clk tick.
// Optional refractory counters are built when LIF_REFRACTORY_EN is defined.
module lif_neuron_array
    import snn_pkg::*;
#(
    parameter int N_NEURONS    = 4,
    parameter int IDX_W        = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int ACC_W        = ACC_W_DEF,
    parameter int SHIFT_VALUE  = 2,
    parameter logic signed [ACC_W-1:0] THRESHOLD = 100,
    parameter int REFRAC_TICKS = 2
) (
    input  logic                     sys_clk,
    input  logic                     rst,
    input  logic                     snn_clk,
    input  logic                     boot_mode,
    input  logic                     data_ready,
    input  logic [IDX_W-1:0]         din_idx,
    input  logic signed [DATA_W-1:0] din,
    output logic [N_NEURONS-1:0]     spike,
    output logic                     spike_valid,
    output logic                     busy,
    output logic                     overrun
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

    lif_state_t state_reg, state_next;
    logic [IDX_W-1:0] i_reg;
    logic             busy_int, last_update, tick_accept;

    logic signed [ACC_W-1:0]  v_arr      [N_NEURONS];
    logic signed [ACC_W-1:0]  shadow_arr [N_NEURONS];
    logic signed [DATA_W-1:0] bias_arr   [N_NEURONS];
    logic [N_NEURONS-1:0]     refrac_vec, spk_vec, spk_now;
    logic [N_NEURONS-1:0]     spike_reg;
    logic                     overrun_reg;

    logic signed [ACC_W-1:0]  core_v_new;
    logic                     core_fire;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (snn_clk) state_next = UPDATE;
            UPDATE:  if (i_reg == LAST_IDX) state_next = DONE;
            DONE:    state_next = snn_clk ? UPDATE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy_int    = (state_reg == UPDATE);
        last_update = busy_int && (i_reg == LAST_IDX);
        tick_accept = snn_clk && !busy_int;
        spike_valid = (state_reg == DONE);
    end

    always_ff @(posedge sys_clk) begin
        if (rst || !busy_int) begin
            i_reg <= '0;
        end else begin
            i_reg <= i_reg + 1'b1;
        end
    end

    lif_update_core #(
        .DATA_W      (DATA_W),
        .ACC_W       (ACC_W),
        .SHIFT_VALUE (SHIFT_VALUE),
        .THRESHOLD   (THRESHOLD)
    ) u_core (
        .v             (v_arr[i_reg]),
        .shadow        (shadow_arr[i_reg]),
        .bias          (bias_arr[i_reg]),
        .refrac_active (refrac_vec[i_reg]),
        .v_new         (core_v_new),
        .fire          (core_fire)
    );

    // The last neuron's result is still combinational when the spike vector is captured.
    always_comb begin
        spk_now = spk_vec;
        for (int k = 0; k < N_NEURONS; k++) begin
            if (k == int'(i_reg)) spk_now[k] = core_fire;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            spike_reg   <= '0;
            overrun_reg <= 1'b0;
        end else begin
            if (last_update) spike_reg <= spk_now;
            if (snn_clk && busy_int) overrun_reg <= 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_NEURONS; gi++) begin : g_neuron
            logic signed [ACC_W-1:0]  acc_reg, acc_next, shadow_reg, v_reg;
            logic signed [DATA_W-1:0] bias_reg;
            logic signed [63:0]       acc_sum, acc_sat;
            logic                     spk_reg, hit, sel;

            assign hit = data_ready && (din_idx == IDX_W'(gi));
            assign sel = busy_int && (i_reg == IDX_W'(gi));

            // A coincident tick clears the accumulator before this cycle's input lands.
            always_comb begin
                acc_sum  = (tick_accept ? 64'sd0 : 64'(acc_reg)) + 64'(din);
                acc_sat  = sat_to_width(acc_sum, ACC_W);
                acc_next = tick_accept ? '0 : acc_reg;
                if (hit && !boot_mode) acc_next = acc_sat[ACC_W-1:0];
            end

            always_ff @(posedge sys_clk) begin
                if (rst) begin
                    acc_reg    <= '0;
                    shadow_reg <= '0;
                    v_reg      <= '0;
                    bias_reg   <= '0;
                    spk_reg    <= 1'b0;
                end else begin
                    acc_reg <= acc_next;
                    if (tick_accept) shadow_reg <= acc_reg;
                    if (hit && boot_mode) bias_reg <= din;
                    if (sel) begin
                        v_reg   <= core_v_new;
                        spk_reg <= core_fire;
                    end
                end
            end

            assign v_arr[gi]      = v_reg;
            assign shadow_arr[gi] = shadow_reg;
            assign bias_arr[gi]   = bias_reg;
            assign spk_vec[gi]    = spk_reg;

`ifdef LIF_REFRACTORY_EN
            localparam int RW = (REFRAC_TICKS > 0) ? $clog2(REFRAC_TICKS + 1) : 1;
            logic [RW-1:0] refrac_reg;

            always_ff @(posedge sys_clk) begin
                if (rst) begin
                    refrac_reg <= '0;
                end else if (sel) begin
                    if (refrac_reg != '0) begin
                        refrac_reg <= refrac_reg - 1'b1;
                    end else if (core_fire) begin
                        refrac_reg <= RW'(REFRAC_TICKS);
                    end
                end
            end

            assign refrac_vec[gi] = (refrac_reg != '0);
`else
            assign refrac_vec[gi] = 1'b0;
`endif
        end
    endgenerate

    assign spike   = spike_reg;
    assign busy    = busy_int;
    assign overrun = overrun_reg;

endmodule

// File: tb/tb_lif_neuron_array.sv
// Scoreboard bench for lif_neuron_array: reference model predicts each sweep, monitor checks spike_valid.
module tb_lif_neuron_array;

    localparam int N = 4;
    localparam longint ACC_MAX = 8388607;
    localparam longint ACC_MIN = -8388608;
    localparam longint THR = 100;
    localparam int REFRAC = 2;

    logic              sys_clk = 1'b0;
    logic              rst = 1'b1;
    logic              snn_clk = 1'b0;
    logic              boot_mode = 1'b0;
    logic              data_ready = 1'b0;
    logic [2:0]        din_idx = '0;
    logic signed [15:0] din = '0;
    logic [N-1:0]      spike;
    logic              spike_valid;
    logic              busy;
    logic              overrun;

    lif_neuron_array #(
        .N_NEURONS    (N),
        .IDX_W        (3),
        .DATA_W       (16),
        .ACC_W        (24),
        .SHIFT_VALUE  (2),
        .THRESHOLD    (24'sd100),
        .REFRAC_TICKS (REFRAC)
    ) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .snn_clk     (snn_clk),
        .boot_mode   (boot_mode),
        .data_ready  (data_ready),
        .din_idx     (din_idx),
        .din         (din),
        .spike       (spike),
        .spike_valid (spike_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [N-1:0] spk;
        int           at_cycle;
    } exp_t;
    exp_t sb[$];

    // Reference model state
    longint m_acc[N], m_v[N], m_bias[N];
    int     m_ref[N];
    int     busy_until = -100;
    bit     exp_overrun = 1'b0;

    function automatic longint clamp(input longint x);
        if (x > ACC_MAX) return ACC_MAX;
        if (x < ACC_MIN) return ACC_MIN;
        return x;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_acc[i] = 0; m_v[i] = 0; m_bias[i] = 0; m_ref[i] = 0;
        end
        busy_until  = -100;
        exp_overrun = 1'b0;
        sb.delete();
    endfunction

    // One tick: every neuron leaks a quarter of the way toward (input + bias).
    function automatic void model_tick(input int c);
        exp_t e;
        longint d, vn;
        if (c <= busy_until) begin
            exp_overrun = 1'b1;
            return;
        end
        e.spk = '0;
        for (int i = 0; i < N; i++) begin
`ifdef LIF_REFRACTORY_EN
            if (m_ref[i] > 0) begin
                m_ref[i]--;
                m_v[i] = 0;
                m_acc[i] = 0;
                continue;
            end
`endif
            d  = m_acc[i] + m_bias[i] - m_v[i];
            vn = clamp(m_v[i] + (d >>> 2));
            if (vn >= THR) begin
                e.spk[i] = 1'b1;
                m_v[i]   = 0;
                m_ref[i] = REFRAC;
            end else begin
                m_v[i] = vn;
            end
            m_acc[i] = 0;
        end
        busy_until = c + N;
        e.at_cycle = c + N + 1;
        sb.push_back(e);
    endfunction

    task automatic drive(input bit tk, input bit bt, input bit dr, input int idx, input int val);
        snn_clk    = tk;
        boot_mode  = bt;
        data_ready = dr;
        din_idx    = 3'(idx);
        din        = 16'(val);
        if (tk) model_tick(cyc);
        if (dr && idx < N) begin
            if (bt) m_bias[idx] = val;
            else    m_acc[idx] = clamp(m_acc[idx] + val);
        end
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic wait_sweep();
        repeat (N + 2) idle();
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_quiet_outputs(input string tag);
        check({tag, "_spike"}, longint'(spike), 0);
        check({tag, "_spike_valid"}, longint'(spike_valid), 0);
        check({tag, "_busy"}, longint'(busy), 0);
        check({tag, "_overrun"}, longint'(overrun), 0);
    endtask

    // Monitor: every spike_valid pulse must match the oldest predicted sweep, on the predicted cycle.
    always @(negedge sys_clk) begin
        if (spike_valid) begin
            exp_t e;
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_spike_valid: got spike=%b at cycle %0d, required no pulse", spike, cyc);
            end else begin
                e = sb.pop_front();
                if (spike !== e.spk || cyc != e.at_cycle) begin
                    miscompares++;
                    $display("FAIL sweep_result: got spike=%b at cycle %0d, required spike=%b at cycle %0d",
                             spike, cyc, e.spk, e.at_cycle);
                end else begin
                    $display("sweep ok: spike=%b at cycle %0d", spike, cyc);
                end
            end
        end
    end

    initial begin
        model_reset();
        rst = 1'b1;
        repeat (3) idle();
        check_quiet_outputs("reset");
        rst = 1'b0;
        idle();

        // Threshold hit on neuron 0
        drive(0, 0, 1, 0, 400);
        drive(1, 0, 0, 0, 0);
        wait_sweep();

        // Leaky integration on neuron 1 over three windows
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 1, 1, 200);
            drive(1, 0, 0, 0, 0);
            wait_sweep();
        end

        // Bias and negative input on neuron 2
        drive(0, 1, 1, 2, 40);
        drive(0, 0, 1, 2, -400);
        drive(1, 0, 0, 0, 0);
        wait_sweep();
        drive(1, 0, 0, 0, 0);
        wait_sweep();

        // Input coincident with tick belongs to the next window
        drive(1, 0, 1, 3, 400);
        wait_sweep();
        drive(1, 0, 0, 0, 0);
        wait_sweep();

        // Tick while busy only sets overrun
        check("overrun_before", longint'(overrun), 0);
        drive(1, 0, 0, 0, 0);
        idle();
        check("busy_during_sweep", longint'(busy), 1);
        drive(1, 0, 1, 0, 50);
        idle();
        check("overrun_after_busy_tick", longint'(overrun), longint'(exp_overrun));
        wait_sweep();

        // Out-of-range index is dropped
        drive(0, 0, 1, 5, 400);
        drive(0, 1, 1, 5, 90);
        drive(1, 0, 0, 0, 0);
        wait_sweep();

        // Accumulator saturation: wrap-around would leave a large negative value instead of 32767
        repeat (600) drive(0, 0, 1, 1, 32767);
        repeat (255) drive(0, 0, 1, 1, -32768);
        drive(1, 0, 0, 0, 0);
        wait_sweep();

`ifdef LIF_REFRACTORY_EN
        drive(0, 0, 1, 0, 400);
        drive(1, 0, 0, 0, 0);
        wait_sweep();
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 1, 0, 400);
            drive(1, 0, 0, 0, 0);
            wait_sweep();
        end
`endif

        // Randomized windows
        for (int w = 0; w < 40; w++) begin
            int n;
            n = int'($urandom_range(0, 6));
            for (int j = 0; j < n; j++) begin
                if ($urandom_range(0, 7) == 0)
                    drive(0, 1, 1, int'($urandom_range(0, 5)), int'($urandom_range(0, 120)) - 40);
                else
                    drive(0, 0, 1, int'($urandom_range(0, 5)), int'($urandom_range(0, 700)) - 300);
            end
            drive(1, 0, $urandom_range(0, 1) == 1, int'($urandom_range(0, 5)), int'($urandom_range(0, 700)) - 300);
            for (int j = 0; j < N + 1; j++) begin
                drive((j < N) && ($urandom_range(0, 5) == 0), 0, $urandom_range(0, 1) == 1,
                      int'($urandom_range(0, 5)), int'($urandom_range(0, 700)) - 300);
            end
            idle();
            check("overrun_random", longint'(overrun), longint'(exp_overrun));
        end

        // Reset in the middle of a sweep
        drive(0, 0, 1, 0, 400);
        drive(1, 0, 0, 0, 0);
        idle();
        rst = 1'b1;
        model_reset();
        idle();
        rst = 1'b0;
        check_quiet_outputs("reset_mid_sweep");

        drive(0, 0, 1, 2, 400);
        drive(1, 0, 0, 0, 0);
        repeat (2 * N) idle();
        check("scoreboard_drained", longint'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
